ps2_rx_fifo: RTL and testbench

Parametrised PS/2 keyboard receiver with an 8-bit memory-mapped slave interface, a scancode FIFO, frame checking and a maskable level interrupt. It is the successor to the single-byte keyboard port. It adds an input glitch filter, start/parity/stop validation, a watchdog for stalled frames, sticky error flags and multi-byte buffering. It sits between the PS/2 connector pins and the CPU bus, and its irq goes to the interrupt controller.

---
 rtl/ps2_rx_fifo.sv | 139 +++++++++++++
 tb/tb_ps2_rx_fifo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with glitch filter, frame checking, watchdog,
// scancode FIFO, sticky error flags and a maskable registered interrupt.
module ps2_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       irq,
  input  logic       s_cs_n,
  input  logic       s_address,
  input  logic       s_read,
  output logic [7:0] s_readdata,
  input  logic       s_write,
  input  logic [7:0] s_writedata,
  input  logic       kc,
  input  logic       kd
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] kc_sync_q, kd_sync_q;
  logic kc_s, kd_s, kc_f_q, kc_f_d, kc_fp_q, strobe, timeout;
  logic [FW-1:0] filt_q, filt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic pbit_q, pbit_d, par_ok;
  logic [WW-1:0] wd_q, wd_d;
  logic push, perr_set, ferr_set;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic empty, full, pop, flush, ctl_wr, clr, wr_en, ovf_set;
  logic ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic unused_wd;
  assign unused_wd = ^s_writedata[7:2];
  assign kc_s = kc_sync_q[SYNC_STAGES-1];
  assign kd_s = kd_sync_q[SYNC_STAGES-1];
  assign strobe = kc_fp_q & ~kc_f_q;
  assign timeout = (state_q != IDLE) & (wd_q == WW'(TIMEOUT_CYCLES));
  assign par_ok = ^{shift_q, pbit_q};
  // filtered kc flips only once the synchronised level has disagreed for FILTER_LEN cycles
  always_comb begin
    kc_f_d = (kc_s != kc_f_q && filt_q == FW'(FILTER_LEN - 1)) ? kc_s : kc_f_q;
    filt_d = (kc_s == kc_f_q || kc_f_d != kc_f_q) ? '0 : filt_q + FW'(1);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (timeout) state_d = IDLE;
    else if (strobe)
      case (state_q)
        IDLE:    state_d = kd_s ? IDLE : DATA;
        DATA:    state_d = (bit_q == 3'd7) ? PARITY : DATA;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    push     = strobe & ~timeout & (state_q == STOP) & kd_s & par_ok;
    perr_set = strobe & ~timeout & (state_q == STOP) & kd_s & ~par_ok;
    ferr_set = timeout | (strobe & (((state_q == IDLE) & kd_s) | ((state_q == STOP) & ~kd_s)));
  end
  always_comb begin
    bit_d   = (strobe && state_q == IDLE) ? 3'd0 : (strobe && state_q == DATA) ? bit_q + 3'd1 : bit_q;
    shift_d = (strobe && state_q == DATA) ? {kd_s, shift_q[7:1]} : shift_q;
    pbit_d  = (strobe && state_q == PARITY) ? kd_s : pbit_q;
    wd_d    = (state_q == IDLE || strobe || timeout) ? '0 : wd_q + WW'(1);
  end
  // a flush wins over a same-cycle push; a pop makes room for a push into a full FIFO
  always_comb begin
    empty    = cnt_q == '0;
    full     = cnt_q == CW'(DEPTH);
    pop      = ~s_cs_n & s_read & ~s_address & ~empty;
    flush    = ~s_cs_n & s_write & ~s_address;
    ctl_wr   = ~s_cs_n & s_write & s_address;
    clr      = ctl_wr & s_writedata[1];
    wr_en    = push & ~flush & (~full | pop);
    ovf_set  = push & ~flush & full & ~pop;
    wr_d     = flush ? '0 : wr_q + AW'(wr_en);
    rd_d     = flush ? '0 : rd_q + AW'(pop);
    cnt_d    = flush ? '0 : cnt_q + CW'(wr_en) - CW'(pop);
    ovf_d    = ovf_set | (ovf_q & ~clr);
    perr_d   = perr_set | (perr_q & ~clr);
    ferr_d   = ferr_set | (ferr_q & ~clr);
    irq_en_d = ctl_wr ? s_writedata[0] : irq_en_q;
    irq_d    = irq_en_q & (~empty | ovf_q | perr_q | ferr_q);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      kc_sync_q <= '1;
      kd_sync_q <= '1;
      kc_f_q    <= 1'b1;
      kc_fp_q   <= 1'b1;
      filt_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      pbit_q    <= 1'b0;
      wd_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      irq_en_q  <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      kc_sync_q <= {kc_sync_q[SYNC_STAGES-2:0], kc};
      kd_sync_q <= {kd_sync_q[SYNC_STAGES-2:0], kd};
      kc_f_q    <= kc_f_d;
      kc_fp_q   <= kc_f_q;
      filt_q    <= filt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      pbit_q    <= pbit_d;
      wd_q      <= wd_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= shift_q;
  assign irq = irq_q;
  assign s_readdata = s_address ? {~empty, full, ovf_q, perr_q, ferr_q, 2'b00, irq_en_q}
                                : (empty ? 8'h00 : mem_q[rd_q]);
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: randomized PS/2 frames and bus traffic checked every idle cycle against
// a queue-based model of the receiver, plus literal expectations for the directed scenarios.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 4, FL = 8, TO = 2000, H = 40;
  logic clk = 0, reset_n = 0, irq, s_cs_n = 1, s_address = 0, s_read = 0, s_write = 0;
  logic [7:0] s_readdata, s_writedata = 0, d;
  logic kc = 1, kd = 1;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  bit m_ovf, m_perr, m_ferr, m_en = 1, busy = 1, prev_f = 0;

  ps2_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq), .s_cs_n(s_cs_n), .s_address(s_address),
    .s_read(s_read), .s_readdata(s_readdata), .s_write(s_write), .s_writedata(s_writedata),
    .kc(kc), .kd(kd));

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {q.size() != 0, q.size() == DEPTH, m_ovf, m_perr, m_ferr, 2'b00, m_en};
  endfunction
  function automatic logic [7:0] m_data();
    return (q.size() != 0) ? q[0] : 8'h00;
  endfunction
  function automatic bit m_irqf();
    return m_en & (q.size() != 0 | m_ovf | m_perr | m_ferr);
  endfunction

  // irq is registered, so it reflects the model as it stood one cycle earlier
  always @(negedge clk) begin
    if (!reset_n) prev_f = 0;
    else begin
      if (!busy) begin
        chk("rdata", s_readdata, s_address ? m_status() : m_data());
        chk("irq", {7'b0, irq}, {7'b0, prev_f});
      end
      prev_f = m_irqf();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input logic a, output logic [7:0] v);
    s_cs_n = 0; s_read = 1; s_address = a;
    @(negedge clk);
    v = s_readdata;
    @(posedge clk);
    #1;
    if (!a && q.size() != 0) void'(q.pop_front());
    s_cs_n = 1; s_read = 0;
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] v);
    s_cs_n = 0; s_write = 1; s_address = a; s_writedata = v;
    cyc(1);
    if (!a) q.delete();
    else begin
      m_en = v[0];
      if (v[1]) {m_ovf, m_perr, m_ferr} = 3'b000;
    end
    s_cs_n = 1; s_write = 0;
  endtask

  task automatic bus_nop(input logic a);
    s_cs_n = 1; s_read = 1; s_write = 1'($urandom); s_address = a;
    cyc(1);
    s_read = 0; s_write = 0;
  endtask

  // nbits < 11 truncates the frame; it then ends by watchdog or, with rst set, by reset
  task automatic send(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch, input bit rst);
    logic [10:0] f;
    busy = 1;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kd = f[i]; cyc(H); kc = 0; cyc(H); kc = 1;
      if (i == glitch) begin cyc(H / 2); kc = 0; cyc(3); kc = 1; end
    end
    kd = 1;
    if (nbits == 11) begin
      cyc(4);
      if (bad_par) m_perr = 1;
      else if (q.size() < DEPTH) q.push_back(b);
      else m_ovf = 1;
    end else if (rst) begin
      cyc(7); reset_n = 0; cyc(3);
      q.delete(); {m_ovf, m_perr, m_ferr} = 3'b000; m_en = 1;
      reset_n = 1; cyc(2);
    end else begin
      cyc(TO + 50);
      m_ferr = 1;
    end
    cyc(3);
    busy = 0;
  endtask

  initial begin
    cyc(5); reset_n = 1; cyc(3); busy = 0; cyc(2);
    bus_rd(1, d); chk("rst_status", d, 8'h01);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    bus_rd(0, d); chk("rst_empty_read", d, 8'h00);
    send(8'h1C, 0, 11, -1, 0);
    bus_rd(1, d); chk("t1_status", d, 8'h81);
    chk("t1_irq", {7'b0, irq}, 8'h01);
    bus_rd(0, d); chk("t1_data", d, 8'h1C);
    cyc(1); chk("t1_irq_off", {7'b0, irq}, 8'h00);
    bus_rd(1, d); chk("t1_status2", d, 8'h01);
    send(8'hF0, 1, 11, -1, 0);
    bus_rd(1, d); chk("t2_status", d, 8'h11);
    chk("t2_irq", {7'b0, irq}, 8'h01);
    bus_wr(1, 8'h03); cyc(1);
    bus_rd(1, d); chk("t2_cleared", d, 8'h01);
    chk("t2_irq_off", {7'b0, irq}, 8'h00);
    for (int i = 1; i <= 5; i++) send(8'(i), 0, 11, -1, 0);
    bus_rd(1, d); chk("t3_full", d, 8'hE1);
    for (int i = 1; i <= 4; i++) begin bus_rd(0, d); chk("t3_data", d, 8'(i)); end
    bus_rd(0, d); chk("t3_empty", d, 8'h00);
    bus_rd(1, d); chk("t3_status", d, 8'h21);
    bus_wr(1, 8'h03);
    send(8'h00, 0, 4, -1, 0);
    bus_rd(1, d); chk("t4_timeout", d, 8'h09);
    send(8'h5A, 0, 11, -1, 0);
    bus_rd(0, d); chk("t4_data", d, 8'h5A);
    bus_wr(1, 8'h03);
    send(8'h29, 0, 11, 3, 0);
    bus_rd(1, d); chk("t5_status", d, 8'h81);
    bus_rd(0, d); chk("t5_data", d, 8'h29);
    bus_wr(1, 8'h00);
    send(8'h33, 0, 5, -1, 1);
    send(8'h76, 0, 11, -1, 0);
    bus_rd(1, d); chk("t6_status", d, 8'h81);
    bus_rd(0, d); chk("t6_data", d, 8'h76);
    bus_rd(1, d); chk("t6_status2", d, 8'h01);
    send(8'hA5, 0, 11, -1, 0);
    send(8'h3C, 0, 11, -1, 0);
    bus_wr(0, 8'hFF);
    bus_rd(1, d); chk("flush_status", d, 8'h01);
    for (int n = 0; n < 30; n++) begin
      send(8'($urandom), $urandom_range(7) == 0, 11, -1, 0);
      repeat ($urandom_range(3)) begin
        case ($urandom_range(9))
          0, 1, 2, 3: bus_rd(0, d);
          4, 5:       bus_rd(1, d);
          6:          bus_nop(1'($urandom));
          7, 8:       bus_wr(1, {6'($urandom), 1'($urandom), $urandom_range(3) != 0});
          default:    bus_wr(0, 8'($urandom));
        endcase
      end
      s_address = 1'($urandom);
      cyc(2);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
